// File: rtl/zc_period_tracker.sv
// zc_period_tracker
// Multi-channel zero-crossing period tracker. Each channel removes a bias,
// classifies the sample against a hysteresis band and measures the number of
// samples between rising (LOW -> HIGH) crossings. It averages 2^log_avg
// intervals and offers one tagged result per channel on a round-robin
// AXI-stream output. It also latches the rising-crossing count per pps second.
module zc_period_tracker #(
    parameter int NUM_CH      = 2,
    parameter int WIDTH       = 16,
    parameter int CNT_WIDTH   = 24,
    parameter int MAX_LOG_AVG = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            threshold,
    input  logic [NUM_CH*WIDTH-1:0]     offset,
    input  logic [2:0]                  log_avg,
    input  logic                        pps,
    input  logic [NUM_CH*WIDTH-1:0]     i_tdata,
    input  logic                        i_tlast,
    input  logic                        i_tvalid,
    output logic                        i_tready,
    output logic [CNT_WIDTH-1:0]        o_tdata,
    output logic [7:0]                  o_tuser,
    output logic                        o_tlast,
    output logic                        o_tvalid,
    input  logic                        o_tready,
    output logic [NUM_CH*CNT_WIDTH-1:0] crossings_per_sec,
    output logic [NUM_CH-1:0]           locked
);

    localparam int XW    = WIDTH + 1;
    localparam int ACC_W = CNT_WIDTH + MAX_LOG_AVG;
    localparam int NW    = MAX_LOG_AVG + 1;
    localparam int GW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2
    } hyst_t;

    logic                   s1_valid_r;
    logic signed [XW-1:0]   x_r        [NUM_CH];
    logic signed [XW-1:0]   diff_s     [NUM_CH];
    logic signed [XW:0]     xe_s       [NUM_CH];
    logic signed [XW:0]     thr_s;
    hyst_t                  state_r    [NUM_CH];
    hyst_t                  state_nx_s [NUM_CH];
    logic [NUM_CH-1:0]      cross_s;
    logic [NUM_CH-1:0]      armed_r;
    logic [CNT_WIDTH-1:0]   cnt_r      [NUM_CH];
    logic [NUM_CH-1:0]      cnt_sat_s;
    logic [ACC_W-1:0]       acc_r      [NUM_CH];
    logic [ACC_W-1:0]       sum_s      [NUM_CH];
    logic [NW-1:0]          n_r        [NUM_CH];
    logic [NW-1:0]          n_inc_s    [NUM_CH];
    logic [NW-1:0]          n_tgt_s;
    logic [CNT_WIDTH-1:0]   avg_s      [NUM_CH];
    logic [CNT_WIDTH-1:0]   result_r   [NUM_CH];
    logic [NUM_CH-1:0]      pending_r;
    logic [2:0]             la_s;
    logic [2:0]             la_r;
    logic                   la_change_s;
    logic                   s2_fire_s;
    logic                   accept_s;
    logic                   load_s;
    logic [GW-1:0]          last_grant_r;
    logic [GW-1:0]          grant_s;
    logic [GW-1:0]          idx_s;
    logic                   found_s;
    logic                   pps_r;
    logic                   pps_edge_s;
    logic [CNT_WIDTH-1:0]   sec_cnt_r  [NUM_CH];
    logic                   unused_s;

    // Beats carry no framing; tlast is accepted and dropped.
    assign unused_s    = i_tlast;
    assign o_tlast     = 1'b1;

    // S2 may only consume S1 when no result is waiting for the output register,
    // so a result can never be overwritten.
    assign s2_fire_s   = s1_valid_r & ~(|pending_r);
    assign i_tready    = ~s1_valid_r | s2_fire_s;
    assign accept_s    = i_tvalid & i_tready;
    assign load_s      = (~o_tvalid | o_tready) & (|pending_r);
    assign pps_edge_s  = pps & ~pps_r;
    assign thr_s       = {2'b00, threshold};
    assign n_tgt_s     = NW'(1'b1) << la_r;
    assign la_change_s = (la_s != la_r);

    // Clamp the averaging exponent to the supported range
    always_comb begin
        if (log_avg > 3'(MAX_LOG_AVG)) begin
            la_s = 3'(MAX_LOG_AVG);
        end else begin
            la_s = log_avg;
        end
    end

    // Bias removal at one extra bit so the subtraction cannot overflow
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            diff_s[c] = {i_tdata[(NUM_CH-1-c)*WIDTH + WIDTH-1], i_tdata[(NUM_CH-1-c)*WIDTH +: WIDTH]}
                      - {offset[(NUM_CH-1-c)*WIDTH + WIDTH-1], offset[(NUM_CH-1-c)*WIDTH +: WIDTH]};
        end
    end

    // Per-channel hysteresis decision, crossing detect and averaging arithmetic
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            xe_s[c] = {x_r[c][XW-1], x_r[c]};
            if (xe_s[c] > thr_s) begin
                state_nx_s[c] = ST_HIGH;
            end else if (xe_s[c] < -thr_s) begin
                state_nx_s[c] = ST_LOW;
            end else begin
                state_nx_s[c] = state_r[c];
            end
            cross_s[c]   = s2_fire_s && (state_r[c] == ST_LOW) && (state_nx_s[c] == ST_HIGH);
            cnt_sat_s[c] = &cnt_r[c];
            sum_s[c]     = acc_r[c] + ACC_W'(cnt_r[c]);
            n_inc_s[c]   = n_r[c] + NW'(1'b1);
            avg_s[c]     = CNT_WIDTH'(sum_s[c] >> la_r);
        end
    end

    // Round-robin grant starting after the last granted channel
    always_comb begin
        grant_s = last_grant_r;
        found_s = 1'b0;
        idx_s   = last_grant_r;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx_s = GW'((int'(last_grant_r) + k) % NUM_CH);
            if (!found_s && pending_r[idx_s]) begin
                grant_s = idx_s;
                found_s = 1'b1;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Stage 1: register the de-biased sample beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                x_r[c] <= {XW{1'b0}};
            end
        end else if (clear) begin
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                x_r[c] <= diff_s[c];
            end
        end else if (s2_fire_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Track the averaging exponent so a change can restart every average
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            la_r <= 3'd0;
        end else begin
            la_r <= la_s;
        end
    end

    // Stage 2: hysteresis state, interval counting, averaging and pending flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {NUM_CH{1'b0}};
            armed_r   <= {NUM_CH{1'b0}};
            locked    <= {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                state_r[c]  <= ST_UNKNOWN;
                cnt_r[c]    <= {CNT_WIDTH{1'b0}};
                acc_r[c]    <= {ACC_W{1'b0}};
                n_r[c]      <= {NW{1'b0}};
                result_r[c] <= {CNT_WIDTH{1'b0}};
            end
        end else if (clear) begin
            pending_r <= {NUM_CH{1'b0}};
            armed_r   <= {NUM_CH{1'b0}};
            locked    <= {NUM_CH{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                state_r[c] <= ST_UNKNOWN;
                cnt_r[c]   <= {CNT_WIDTH{1'b0}};
                acc_r[c]   <= {ACC_W{1'b0}};
                n_r[c]     <= {NW{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // pending is only set while all pending bits are clear, so the
                // output grant and a new result never collide on one channel
                if (load_s && (grant_s == GW'(c))) begin
                    pending_r[c] <= 1'b0;
                end
                if (s2_fire_s) begin
                    state_r[c] <= state_nx_s[c];
                    if (cross_s[c]) begin
                        cnt_r[c] <= CNT_WIDTH'(1'b1);
                        if (!armed_r[c]) begin
                            armed_r[c] <= 1'b1;
                        end else if (cnt_sat_s[c]) begin
                            // interval too long to measure: restart the average
                            acc_r[c]  <= {ACC_W{1'b0}};
                            n_r[c]    <= {NW{1'b0}};
                            locked[c] <= 1'b0;
                        end else if (n_inc_s[c] == n_tgt_s) begin
                            result_r[c]  <= avg_s[c];
                            pending_r[c] <= 1'b1;
                            acc_r[c]     <= {ACC_W{1'b0}};
                            n_r[c]       <= {NW{1'b0}};
                            locked[c]    <= 1'b1;
                        end else begin
                            acc_r[c] <= sum_s[c];
                            n_r[c]   <= n_inc_s[c];
                        end
                    end else if (!cnt_sat_s[c]) begin
                        cnt_r[c] <= cnt_r[c] + CNT_WIDTH'(1'b1);
                    end
                end
                if (la_change_s) begin
                    acc_r[c] <= {ACC_W{1'b0}};
                    n_r[c]   <= {NW{1'b0}};
                end
            end
        end
    end

    // Output register: hold while stalled, load the granted channel's result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_tvalid     <= 1'b0;
            o_tdata      <= {CNT_WIDTH{1'b0}};
            o_tuser      <= 8'd0;
            last_grant_r <= GW'(NUM_CH - 1);
        end else if (load_s) begin
            o_tvalid     <= 1'b1;
            o_tdata      <= result_r[grant_s];
            o_tuser      <= 8'(grant_s);
            last_grant_r <= grant_s;
        end else if (o_tready) begin
            o_tvalid     <= 1'b0;
        end
    end

    // Per-second crossing counters, latched and restarted on each pps edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pps_r             <= 1'b0;
            crossings_per_sec <= {(NUM_CH*CNT_WIDTH){1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                sec_cnt_r[c] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            pps_r <= pps;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pps_edge_s) begin
                    crossings_per_sec[(NUM_CH-1-c)*CNT_WIDTH +: CNT_WIDTH] <= sec_cnt_r[c];
                end
                if (clear) begin
                    sec_cnt_r[c] <= {CNT_WIDTH{1'b0}};
                end else if (pps_edge_s) begin
                    // a crossing on the pps edge belongs to the new second
                    sec_cnt_r[c] <= cross_s[c] ? CNT_WIDTH'(1'b1) : {CNT_WIDTH{1'b0}};
                end else if (cross_s[c] && !(&sec_cnt_r[c])) begin
                    sec_cnt_r[c] <= sec_cnt_r[c] + CNT_WIDTH'(1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_zc_period_tracker.sv
// Directed testbench for zc_period_tracker: square waves, averaging, noise
// rejection, output back-pressure, interval saturation and pps latching.
module tb_zc_period_tracker;

    localparam logic [15:0] HI = 16'd1000;
    localparam logic [15:0] LO = 16'hFC18;
    localparam logic [15:0] ZE = 16'd0;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [15:0] threshold;
    logic [31:0] offset;
    logic [2:0]  log_avg;
    logic        pps;
    logic        i_tlast;
    logic        o_tready;

    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [23:0] o_tdata;
    logic [7:0]  o_tuser;
    logic        o_tlast;
    logic        o_tvalid;
    logic [47:0] cps;
    logic [1:0]  locked;

    logic [31:0] i_tdata8;
    logic        i_tvalid8;
    logic        i_tready8;
    logic [7:0]  o_tdata8;
    logic [7:0]  o_tuser8;
    logic        o_tlast8;
    logic        o_tvalid8;
    logic [15:0] cps8;
    logic [1:0]  locked8;

    logic [31:0] q_data[$];
    logic [7:0]  q_user[$];
    logic [31:0] q_data8[$];
    logic [7:0]  q_user8[$];

    int n_checks;
    int n_pass;

    zc_period_tracker dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .threshold(threshold),
        .offset(offset), .log_avg(log_avg), .pps(pps), .i_tdata(i_tdata),
        .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready),
        .crossings_per_sec(cps), .locked(locked)
    );

    zc_period_tracker #(.CNT_WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .threshold(threshold),
        .offset(offset), .log_avg(log_avg), .pps(pps), .i_tdata(i_tdata8),
        .i_tlast(i_tlast), .i_tvalid(i_tvalid8), .i_tready(i_tready8),
        .o_tdata(o_tdata8), .o_tuser(o_tuser8), .o_tlast(o_tlast8),
        .o_tvalid(o_tvalid8), .o_tready(o_tready),
        .crossings_per_sec(cps8), .locked(locked8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed output handshake, away from the active edge
    always @(negedge clk) begin
        if (o_tvalid && o_tready) begin
            q_data.push_back(32'(o_tdata));
            q_user.push_back(o_tuser);
        end
        if (o_tvalid8 && o_tready) begin
            q_data8.push_back(32'(o_tdata8));
            q_user8.push_back(o_tuser8);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_tvalid  = 1'b0;
        i_tvalid8 = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input bit sel, input logic [15:0] a, input logic [15:0] b);
        logic ok;
        int   guard;
        ok    = 1'b0;
        guard = 0;
        if (sel) begin
            i_tdata8  = {a, b};
            i_tvalid8 = 1'b1;
        end else begin
            i_tdata  = {a, b};
            i_tvalid = 1'b1;
        end
        while (!ok && guard < 40) begin
            ok = sel ? i_tready8 : i_tready;
            step();
            guard++;
        end
        if (!ok) chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic run_period(input int p);
        send(1'b0, HI, ZE);
        repeat (p - 1) send(1'b0, LO, ZE);
    endtask

    task automatic pulse_pps();
        pps = 1'b1;
        step();
        pps = 1'b0;
        step();
    endtask

    task automatic do_reset();
        i_tvalid  = 1'b0;
        i_tvalid8 = 1'b0;
        pps       = 1'b0;
        clear     = 1'b0;
        reset_n   = 1'b0;
        repeat (2) step();
        reset_n   = 1'b1;
        step();
        q_data.delete();
        q_user.delete();
        q_data8.delete();
        q_user8.delete();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        clear     = 1'b0;
        threshold = 16'd100;
        offset    = 32'd0;
        log_avg   = 3'd0;
        pps       = 1'b0;
        i_tlast   = 1'b0;
        o_tready  = 1'b1;
        i_tdata   = 32'd0;
        i_tvalid  = 1'b0;
        i_tdata8  = 32'd0;
        i_tvalid8 = 1'b0;

        // Reset state
        do_reset();
        chk("rst_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst_tdata", 32'(o_tdata), 32'd0);
        chk("rst_tuser", 32'(o_tuser), 32'd0);
        chk("rst_tlast", 32'(o_tlast), 32'd1);
        chk("rst_tlast8", 32'(o_tlast8), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_cps", 32'(cps), 32'd0);
        chk("rst_cps8", 32'(cps8), 32'd0);
        chk("rst_tready", 32'(i_tready), 32'd1);

        // 1: square wave period 10 on both channels, log_avg 0
        for (int p = 0; p < 4; p++) begin
            repeat (5) send(1'b0, LO, LO);
            repeat (5) send(1'b0, HI, HI);
        end
        idle(20);
        chk("t1_count", 32'(q_data.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < q_data.size()) begin
                chk("t1_data", q_data[i], 32'd10);
                chk("t1_user", 32'(q_user[i]), 32'(i % 2));
            end
        end
        chk("t1_locked", 32'(locked), 32'd3);

        // 2: periods 10,11,12,13 averaged over 4 -> 46 >> 2 = 11
        do_reset();
        log_avg = 3'd2;
        send(1'b0, LO, ZE);
        run_period(10);
        run_period(11);
        run_period(12);
        run_period(13);
        idle(5);
        chk("t2_pre_count", 32'(q_data.size()), 32'd0);
        chk("t2_pre_locked", 32'(locked), 32'd0);
        send(1'b0, HI, ZE);
        idle(10);
        chk("t2_count", 32'(q_data.size()), 32'd1);
        if (q_data.size() > 0) begin
            chk("t2_data", q_data[0], 32'd11);
            chk("t2_user", 32'(q_user[0]), 32'd0);
        end
        chk("t2_locked", 32'(locked), 32'd1);

        // 3: +-50 noise around offset 200 stays inside the band
        do_reset();
        log_avg = 3'd0;
        offset  = {16'd200, 16'd0};
        pulse_pps();
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 16'd150, ZE);
            send(1'b0, 16'd250, ZE);
        end
        idle(5);
        pulse_pps();
        chk("t3_cps0", 32'(cps[47:24]), 32'd0);
        chk("t3_count", 32'(q_data.size()), 32'd0);
        chk("t3_locked", 32'(locked), 32'd0);
        offset = 32'd0;

        // 4: simultaneous crossings with the output stalled
        do_reset();
        o_tready = 1'b1;
        send(1'b0, LO, LO);
        send(1'b0, HI, HI);
        repeat (9) send(1'b0, LO, LO);
        o_tready = 1'b0;
        send(1'b0, HI, HI);
        i_tdata = {HI, HI};
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t4_tvalid", 32'(o_tvalid), 32'd1);
            chk("t4_tdata", 32'(o_tdata), 32'd10);
            chk("t4_tuser", 32'(o_tuser), 32'd0);
            chk("t4_tready", 32'(i_tready), 32'd0);
            step();
        end
        o_tready = 1'b1;
        i_tvalid = 1'b0;
        for (int i = 0; i < 20 && q_data.size() < 2; i++) step();
        chk("t4_count", 32'(q_data.size()), 32'd2);
        if (q_data.size() >= 2) begin
            chk("t4_first_user", 32'(q_user[0]), 32'd0);
            chk("t4_second_user", 32'(q_user[1]), 32'd1);
            chk("t4_first_data", q_data[0], 32'd10);
            chk("t4_second_data", q_data[1], 32'd10);
        end

        // 5: CNT_WIDTH 8 instance, saturated interval then period 20
        do_reset();
        send(1'b1, LO, ZE);
        send(1'b1, HI, ZE);
        repeat (9) send(1'b1, LO, ZE);
        send(1'b1, HI, ZE);
        idle(8);
        chk("t5_first_count", 32'(q_data8.size()), 32'd1);
        if (q_data8.size() > 0) chk("t5_first_data", q_data8[0], 32'd10);
        chk("t5_locked_a", 32'(locked8), 32'd1);
        repeat (300) send(1'b1, LO, ZE);
        send(1'b1, HI, ZE);
        idle(8);
        chk("t5_sat_count", 32'(q_data8.size()), 32'd1);
        chk("t5_sat_locked", 32'(locked8), 32'd0);
        repeat (19) send(1'b1, LO, ZE);
        send(1'b1, HI, ZE);
        idle(8);
        chk("t5_final_count", 32'(q_data8.size()), 32'd2);
        if (q_data8.size() > 1) chk("t5_final_data", q_data8[1], 32'd20);
        chk("t5_final_locked", 32'(locked8), 32'd1);

        // 6: pps latching, crossing on the pps edge, mid-stream reset
        do_reset();
        pulse_pps();
        repeat (7) begin
            send(1'b0, LO, ZE);
            send(1'b0, HI, ZE);
        end
        idle(10);
        pulse_pps();
        chk("t6_cps0_seven", 32'(cps[47:24]), 32'd7);
        chk("t6_cps1_zero", 32'(cps[23:0]), 32'd0);
        send(1'b0, LO, ZE);
        idle(10);
        i_tdata  = {HI, ZE};
        i_tvalid = 1'b1;
        step();
        pps      = 1'b1;
        i_tvalid = 1'b0;
        step();
        pps      = 1'b0;
        chk("t6_edge_old_second", 32'(cps[47:24]), 32'd0);
        idle(10);
        pulse_pps();
        chk("t6_edge_new_second", 32'(cps[47:24]), 32'd1);
        o_tready = 1'b0;
        send(1'b0, LO, ZE);
        send(1'b0, HI, ZE);
        idle(5);
        chk("t6_pre_tvalid", 32'(o_tvalid), 32'd1);
        chk("t6_pre_locked", 32'(locked), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 32'(o_tvalid), 32'd0);
        chk("t6_rst_tdata", 32'(o_tdata), 32'd0);
        chk("t6_rst_tuser", 32'(o_tuser), 32'd0);
        chk("t6_rst_tlast", 32'(o_tlast), 32'd1);
        chk("t6_rst_locked", 32'(locked), 32'd0);
        chk("t6_rst_cps", 32'(cps), 32'd0);
        chk("t6_rst_tready", 32'(i_tready), 32'd1);
        step();
        reset_n  = 1'b1;
        o_tready = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zc_period_tracker.md
# zc_period_tracker

Multi-channel zero-crossing period tracker for the doppler tracking chain. It replaces the per-rail detector plus separate moving average with one parametrised block, and sits after the complex moving-average filter in the compute-engine clock domain. Per channel it applies hysteresis around a programmable offset and measures the interval, in samples, between rising crossings. It averages 2^log_avg intervals and emits one tagged result per channel through a round-robin AXI-stream output. Crossings per PPS second are also latched for readback.

## Interface
Parameters:
- NUM_CH, 2: number of packed channels; channel 0 occupies the MSBs of i_tdata.
- WIDTH, 16: signed sample width per channel.
- CNT_WIDTH, 24: interval counter, result and per-second counter width.
- MAX_LOG_AVG, 6: maximum averaging exponent; the accumulator is CNT_WIDTH+MAX_LOG_AVG bits.

Ports:
- clk  in  1  compute-engine clock; the block has one clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of the tracking state.
- threshold  in  WIDTH  unsigned hysteresis half-width.
- offset  in  NUM_CH*WIDTH  signed per-channel bias, packed in the same order as i_tdata.
- log_avg  in  3  averaging exponent; values above MAX_LOG_AVG are clamped to MAX_LOG_AVG.
- pps  in  1  pulse-per-second, synchronous to clk.
- i_tdata  in  NUM_CH*WIDTH  sample beat.
- i_tlast  in  1  ignored.
- i_tvalid  in  1  input handshake.
- i_tready  out  1  input handshake.
- o_tdata  out  CNT_WIDTH  averaged period in samples.
- o_tuser  out  8  channel index of the result.
- o_tlast  out  1  tied to 1; each result is a single-beat packet.
- o_tvalid  out  1  output handshake.
- o_tready  in  1  output handshake.
- crossings_per_sec  out  NUM_CH*CNT_WIDTH  per-channel rising-crossing count latched at each pps edge.
- locked  out  NUM_CH  per channel, high after the first valid averaged result.

## Operation
- **Stage 1 (S1).** An accepted beat is registered as x[c] = sample[c] - offset[c], computed at WIDTH+1 bits signed. This sets s1_valid.
- **Stage 2 (S2).** S2 fires when s1_valid is high and no channel has pending set.
  - i_tready = ~s1_valid | s2_fire.
- **Hysteresis state per channel.** States are UNKNOWN, LOW and HIGH.
  - x < -threshold moves the state to LOW.
  - x > threshold moves the state to HIGH.
  - Values inside the band leave the state unchanged.
  - A rising crossing is the transition LOW to HIGH only. The transition UNKNOWN to HIGH is not a crossing.
- **Interval counter per channel.**
  - On a crossing beat the counter loads 1; on every other S2 beat it increments.
  - It saturates at 2^CNT_WIDTH-1.
  - At a crossing, period = counter value before the reload.
  - The first crossing after reset or clear only arms the channel; it produces no period.
- **Invalid interval.** If the counter is saturated when a crossing occurs:
  - the period is discarded;
  - the accumulator and the sample count n are zeroed;
  - locked[c] is driven to 0.
- **Averaging.**
  - Each valid period is added to acc and increments n.
  - When n reaches 2^log_avg: result = acc >> log_avg (truncating), pending[c] is set, acc and n are zeroed, and locked[c] is driven to 1.
  - Any change in log_avg zeroes acc and n on all channels.
- **Output register.**
  - It loads when o_tvalid is low or o_tready is high, and at least one channel has pending set.
  - The grant is round-robin, starting from the channel after the last one granted.
  - The load clears pending of the granted channel.
  - o_tdata and o_tuser are held stable while o_tvalid is high and o_tready is low.
- **Per-second counting.**
  - A per-channel counter counts every rising crossing, including arming and invalid crossings, and saturates.
  - A pps rising edge, detected with a registered copy of pps, latches the counter into crossings_per_sec and resets the counter to 0.
  - A crossing on the same cycle as the pps edge belongs to the new second: the counter becomes 1.
- **clear.**
  - clear resets s1_valid, the hysteresis state (to UNKNOWN), the arming, the interval counters, acc, n, pending, locked and the running per-second counters.
  - clear does not affect the latched crossings_per_sec values.
  - clear does not withdraw a beat already presented with o_tvalid high.

## Timing
- **Reset values:**
  - o_tvalid = 0, o_tdata = 0, o_tuser = 0, o_tlast = 1.
  - locked = 0, crossings_per_sec = 0.
  - i_tready = 1, all states UNKNOWN.
- **Latency:** a beat accepted on edge t reaches S2 at edge t+1, sets pending at t+1, and loads the output register at t+2. o_tvalid is therefore high in the cycle after edge t+2.
- **Back-pressure:**
  - While any pending bit is set, S1 holds and i_tready drops.
  - A result therefore stalls input for at least one cycle.
  - No result is ever lost or overwritten.
- **Mid-operation reset:** asserting reset_n low mid-operation forces all reset values immediately, without waiting for a clock edge.
- **Priority:** reset_n, then clear, then normal operation.

## Test plan
1. Square wave of ±1000, period 10, on both channels, threshold 100, offset 0, log_avg 0, o_tready held high.
   - Required: after the arming crossing, each channel emits o_tdata = 10 once per period, with o_tuser equal to the channel index.
2. Channel 0 only, periods 10, 11, 12, 13, log_avg 2.
   - Required: exactly one result, o_tdata = 11 (46 >> 2 = 11), and locked[0] rises at that result.
3. Noise of ±50 around offset 200, offset[0] = 200, threshold 100.
   - Required: no output, locked stays 0, and crossings_per_sec latches 0 at the next pps.
4. Both channels cross on the same beat, o_tready held low for 5 cycles.
   - Required: channel 0 is output first, then channel 1.
   - Required: o_tdata and o_tuser stay stable during the stall.
   - Required: i_tready stays low while pending is set.
5. CNT_WIDTH = 8, 300 beats with no crossing, then a crossing, then a period of 20.
   - Required: the first crossing gives no output and locked = 0.
   - Required: the next crossing outputs 20.
6. Seven crossings then a pps pulse: crossings_per_sec = 7.
   - Then a crossing on the same cycle as the next pps edge: that crossing is counted in the following latch.
   - Then reset_n pulsed low mid-stream: all outputs return to their reset values.
